bus_datapath_seq: RTL and testbench
===================================

BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 Parameter DATA_W, default 32: width of bus, registers, Y, HI, LO; Z is 2*DATA_W.
REQ-002 Parameter NUM_REGS, default 16: general registers R0..R(NUM_REGS-1); IDX_W = clog2(NUM_REGS).
REQ-003 clk  in  1: single clock; all state changes on its rising edge.
REQ-004 clr  in  1: reset, synchronous, active-high.
REQ-005 start  in  1: request one operation; sampled only in IDLE.
REQ-006 opcode  in  3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL (signed), 5 NOT; 6-7 illegal.
REQ-007 ra, rb, rc  in  IDX_W each: source A, source B, destination index; sampled with start.
REQ-008 ld_en, ld_idx, ld_data  in  1/IDX_W/DATA_W: direct register preload.
REQ-009 rd_idx  in  IDX_W; rd_data  out  DATA_W: combinational register read.
REQ-010 busy  out  1: high in every state except IDLE.
REQ-011 done  out  1: one-cycle completion pulse; err  out  1: valid only with done, high for illegal opcode.
REQ-012 z_hi, z_lo, hi, lo  out  DATA_W each: Z halves and HI/LO registers; bus_out  out  DATA_W: current bus value.

Function
REQ-013 States: IDLE, LOADY, EXEC, WB, WBH, DONE; one state per cycle.
REQ-014 IDLE with start=1: latch opcode/ra/rb/rc; next state LOADY, or DONE with err=1 if opcode illegal; NOT goes directly to EXEC.
REQ-015 LOADY: bus = R[ra]; Y <= bus; next EXEC.
REQ-016 EXEC: bus = R[rb] (NOT: R[ra]); Z <= f(Y, bus); next WB.
REQ-017 ADD/SUB wrap modulo 2^DATA_W; AND/OR/NOT bitwise; non-MUL ops set Z high half to 0.
REQ-018 MUL: Z = signed(Y) * signed(bus) as full 2*DATA_W two's-complement product.
REQ-019 WB: bus = z_lo; non-MUL: R[rc] <= bus, next DONE; MUL: LO <= bus, next WBH.
REQ-020 WBH (MUL only): bus = z_hi; HI <= bus; next DONE.
REQ-021 DONE: done=1 for exactly this cycle; next IDLE; start in DONE is ignored.
REQ-022 Latency from the start-sampling edge to the done cycle: ADD/SUB/AND/OR 4 cycles, NOT 3, MUL 5, illegal 1.
REQ-023 R0 reads 0 always; writes to R0 from WB or ld_en are discarded without error.
REQ-024 ld_en is honoured only in IDLE with start=0; if start=1 in the same cycle, start wins and ld is dropped; ld_en while busy is dropped.
REQ-025 start while busy is ignored; the operation is not queued.
REQ-026 rc equal to ra or rb is legal; sources are consumed before WB, so the result overwrites.
REQ-027 bus_out is 0 in IDLE and DONE.
REQ-028 Illegal opcode changes no register, Y, Z, HI or LO.

Reset
REQ-029 clr=1 at an edge forces IDLE; clears R0..R(N-1), Y, Z, HI and LO to 0; clears done and err; overrides start and ld_en.
REQ-030 clr during any active state aborts the operation; no write-back occurs and busy=0 in the following cycle.

Structure
REQ-031 Shared package holds: opcode encodings, state enum, DATA_W/NUM_REGS defaults.
REQ-032 One combinational sub-module seq_alu computes the 2*DATA_W result from Y, bus and opcode; the FSM, registers and bus mux stay in bus_datapath_seq.

Verification (DATA_W=32, NUM_REGS=16)
REQ-033 Load R2=5, R3=3; ADD ra=2 rb=3 rc=4 -> done 4 cycles after start, R4=0x00000008, z_hi=0, err=0.
REQ-034 Load R2=3, R3=5; SUB rc=2 -> R2=0xFFFFFFFE; then ADD with R2 and R2=0xFFFFFFFF... wraps: 0xFFFFFFFF+1 -> 0x00000000.
REQ-035 Load R6=0xFFFFFFFF, R7=2; MUL -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, done 5 cycles after start; general registers unchanged.
REQ-036 ld_en to R0 with 0x1234, then ADD rc=0 -> rd_data(R0)=0; opcode 7 -> done one cycle after start with err=1, and all registers unchanged.
REQ-037 Start ADD, assert clr in EXEC -> next cycle busy=0, all registers 0, no done pulse; start asserted during busy is ignored with no second done.

Source files
------------

// File: rtl/bus_datapath_seq_pkg.sv
// Shared definitions for the bus datapath sequencer: default sizes,
// opcode encodings and the control state enum.
package bus_datapath_seq_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADY,
    S_EXEC,
    S_WB,
    S_WBH,
    S_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/bus_datapath_seq_alu.sv
// Combinational ALU: combines the Y register with the current bus value
// into a double-width Z result.
module seq_alu
  import bus_datapath_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0]   y,
  input  logic [DATA_W-1:0]   bus,
  input  logic [2:0]          opcode,
  output logic [2*DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] y_sx;
  logic signed [2*DATA_W-1:0] bus_sx;
  logic signed [2*DATA_W-1:0] prod;

  // Sign-extend to full width so the product keeps every bit of a signed multiply.
  assign y_sx   = {{DATA_W{y[DATA_W-1]}}, y};
  assign bus_sx = {{DATA_W{bus[DATA_W-1]}}, bus};
  assign prod   = y_sx * bus_sx;

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = {{DATA_W{1'b0}}, y + bus};
      OP_SUB:  result = {{DATA_W{1'b0}}, y - bus};
      OP_AND:  result = {{DATA_W{1'b0}}, y & bus};
      OP_OR:   result = {{DATA_W{1'b0}}, y | bus};
      OP_MUL:  result = prod;
      OP_NOT:  result = {{DATA_W{1'b0}}, ~bus};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath: a sequencer moves operands over one
// shared bus through Y, the ALU and Z, then writes back to R[rc] or HI/LO.
module bus_datapath_seq
  import bus_datapath_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [IDX_W-1:0]  ra,
  input  logic [IDX_W-1:0]  rb,
  input  logic [IDX_W-1:0]  rc,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] bus_out
);

  state_e                state;
  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [DATA_W-1:0]     y;
  logic [2*DATA_W-1:0]   z;
  logic [2*DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]     bus;
  logic [2:0]            op_q;
  logic [IDX_W-1:0]      ra_q;
  logic [IDX_W-1:0]      rb_q;
  logic [IDX_W-1:0]      rc_q;

  // Handshake: start is accepted only while busy=0; a request made while busy
  // is dropped, not queued. done pulses for one cycle, err is meaningful only with it.
  always_comb begin
    bus = '0;
    case (state)
      S_LOADY: bus = regs[ra_q];
      S_EXEC:  bus = (op_q == OP_NOT) ? regs[ra_q] : regs[rb_q];
      S_WB:    bus = z[DATA_W-1:0];
      S_WBH:   bus = z[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .y      (y),
    .bus    (bus),
    .opcode (op_q),
    .result (alu_res)
  );

  // R0 is never written, so it reads as zero without a special read path.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= opcode;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
            if (!op_legal(opcode)) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (opcode == OP_NOT) begin
              state <= S_EXEC;
            end else begin
              state <= S_LOADY;
            end
          end else if (ld_en && ld_idx != '0) begin
            regs[ld_idx] <= ld_data;
          end
        end
        S_LOADY: begin
          y     <= bus;
          state <= S_EXEC;
        end
        S_EXEC: begin
          z     <= alu_res;
          state <= S_WB;
        end
        S_WB: begin
          if (op_q == OP_MUL) begin
            lo    <= bus;
            state <= S_WBH;
          end else begin
            if (rc_q != '0) regs[rc_q] <= bus;
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_WBH: begin
          hi    <= bus;
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign rd_data = regs[rd_idx];
  assign z_hi    = z[2*DATA_W-1:DATA_W];
  assign z_lo    = z[DATA_W-1:0];
  assign bus_out = bus;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed self-checking bench for bus_datapath_seq (DATA_W=32, NUM_REGS=16).
module tb_bus_datapath_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [2:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [31:0] z_hi, z_lo, hi, lo, bus_out;

  int total = 0;
  int bad   = 0;

  bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .z_hi(z_hi), .z_lo(z_lo), .hi(hi), .lo(lo), .bus_out(bus_out)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic load_reg(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx; ld_data = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] val);
    rd_idx = idx;
    #1 val = rd_data;
  endtask

  // Issues one operation; lat = cycle (1-based after the sampling edge) where done was seen.
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, output int lat, output logic e);
    lat = -1;
    e   = 1'bx;
    @(negedge clk);
    start = 1'b1; opcode = op; ra = a; rb = b; rc = c;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        e   = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] v;
    clr = 1'b1; start = 1'b0; opcode = 3'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0;
    ld_en = 1'b0; ld_idx = 4'd0; ld_data = 32'd0; rd_idx = 4'd0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    total++; if ({z_hi, z_lo} !== 64'd0) begin bad++; $display("FAIL reset_z: got %h expected 0", {z_hi, z_lo}); end
    total++; if (bus_out !== 32'd0) begin bad++; $display("FAIL reset_bus: got %h expected 0", bus_out); end
    read_reg(4'd5, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_r5: got %h expected 0", v); end
  endtask

  task automatic test_add();
    int lat; logic e; logic [31:0] v;
    load_reg(4'd2, 32'd5);
    load_reg(4'd3, 32'd3);
    run_op(3'd0, 4'd2, 4'd3, 4'd4, lat, e);
    total++; if (lat !== 4) begin bad++; $display("FAIL add_latency: got %0d expected 4", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL add_err: got %b expected 0", e); end
    total++; if (z_hi !== 32'd0) begin bad++; $display("FAIL add_zhi: got %h expected 0", z_hi); end
    total++; if (z_lo !== 32'd8) begin bad++; $display("FAIL add_zlo: got %h expected 8", z_lo); end
    read_reg(4'd4, v);
    total++; if (v !== 32'h0000_0008) begin bad++; $display("FAIL add_r4: got %h expected 00000008", v); end
  endtask

  task automatic test_sub_wrap();
    int lat; logic e; logic [31:0] v;
    load_reg(4'd2, 32'd3);
    load_reg(4'd3, 32'd5);
    run_op(3'd1, 4'd2, 4'd3, 4'd2, lat, e);
    read_reg(4'd2, v);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_r2: got %h expected fffffffe", v); end
    total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency: got %0d expected 4", lat); end
    load_reg(4'd5, 32'hFFFF_FFFF);
    load_reg(4'd6, 32'd1);
    run_op(3'd0, 4'd5, 4'd6, 4'd7, lat, e);
    read_reg(4'd7, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL add_wrap_r7: got %h expected 0", v); end
    total++; if (z_hi !== 32'd0) begin bad++; $display("FAIL add_wrap_zhi: got %h expected 0", z_hi); end
  endtask

  task automatic test_logic();
    int lat; logic e; logic [31:0] v;
    load_reg(4'd8, 32'hF0F0_00FF);
    load_reg(4'd9, 32'h0FF0_0F0F);
    run_op(3'd2, 4'd8, 4'd9, 4'd10, lat, e);
    read_reg(4'd10, v);
    total++; if (v !== 32'h00F0_000F) begin bad++; $display("FAIL and_r10: got %h expected 00f0000f", v); end
    run_op(3'd3, 4'd8, 4'd9, 4'd10, lat, e);
    read_reg(4'd10, v);
    total++; if (v !== 32'hFFF0_0FFF) begin bad++; $display("FAIL or_r10: got %h expected fff00fff", v); end
    run_op(3'd5, 4'd8, 4'd0, 4'd10, lat, e);
    read_reg(4'd10, v);
    total++; if (v !== 32'h0F0F_FF00) begin bad++; $display("FAIL not_r10: got %h expected 0f0fff00", v); end
    total++; if (lat !== 3) begin bad++; $display("FAIL not_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_mul();
    int lat; logic e; logic [31:0] v;
    load_reg(4'd1, 32'h0000_00A5);
    load_reg(4'd6, 32'hFFFF_FFFF);
    load_reg(4'd7, 32'd2);
    run_op(3'd4, 4'd6, 4'd7, 4'd1, lat, e);
    total++; if (lat !== 5) begin bad++; $display("FAIL mul_latency: got %0d expected 5", lat); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mul_err: got %b expected 0", e); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_hi: got %h expected ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_lo: got %h expected fffffffe", lo); end
    total++; if ({z_hi, z_lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mul_z: got %h expected fffffffffffffffe", {z_hi, z_lo}); end
    read_reg(4'd1, v);
    total++; if (v !== 32'h0000_00A5) begin bad++; $display("FAIL mul_r1_kept: got %h expected 000000a5", v); end
    read_reg(4'd6, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_r6_kept: got %h expected ffffffff", v); end
  endtask

  task automatic test_r0_illegal();
    int lat; logic e; logic [31:0] v;
    load_reg(4'd0, 32'h0000_1234);
    read_reg(4'd0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL ld_r0: got %h expected 0", v); end
    load_reg(4'd2, 32'd5);
    load_reg(4'd3, 32'd3);
    load_reg(4'd4, 32'h0000_0044);
    run_op(3'd0, 4'd2, 4'd3, 4'd0, lat, e);
    read_reg(4'd0, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL wb_r0: got %h expected 0", v); end
    run_op(3'd7, 4'd2, 4'd3, 4'd4, lat, e);
    total++; if (lat !== 1) begin bad++; $display("FAIL ill_latency: got %0d expected 1", lat); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL ill_err: got %b expected 1", e); end
    read_reg(4'd4, v);
    total++; if (v !== 32'h0000_0044) begin bad++; $display("FAIL ill_r4: got %h expected 00000044", v); end
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL ill_hilo: got %h expected fffffffffffffffe", {hi, lo}); end
    total++; if (z_lo !== 32'd8) begin bad++; $display("FAIL ill_z: got %h expected 8", z_lo); end
  endtask

  task automatic test_back_to_back();
    int ndone; logic [31:0] v;
    load_reg(4'd2, 32'd10);
    load_reg(4'd3, 32'd20);
    load_reg(4'd5, 32'h55);
    load_reg(4'd11, 32'h11);
    load_reg(4'd12, 32'h12);
    @(negedge clk);
    start = 1'b1; opcode = 3'd0; ra = 4'd2; rb = 4'd3; rc = 4'd4;
    ld_en = 1'b1; ld_idx = 4'd11; ld_data = 32'h77;
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      if (done) ndone++;
      if (i == 1) begin
        start = 1'b1; opcode = 3'd0; ra = 4'd2; rb = 4'd3; rc = 4'd5;
        ld_en = 1'b1; ld_idx = 4'd12; ld_data = 32'h99;
      end else begin
        start = 1'b0; ld_en = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
    read_reg(4'd4, v);
    total++; if (v !== 32'd30) begin bad++; $display("FAIL b2b_r4: got %h expected 0000001e", v); end
    read_reg(4'd5, v);
    total++; if (v !== 32'h55) begin bad++; $display("FAIL b2b_r5: got %h expected 00000055", v); end
    read_reg(4'd11, v);
    total++; if (v !== 32'h11) begin bad++; $display("FAIL b2b_ld_start: got %h expected 00000011", v); end
    read_reg(4'd12, v);
    total++; if (v !== 32'h12) begin bad++; $display("FAIL b2b_ld_busy: got %h expected 00000012", v); end
  endtask

  task automatic test_clr_abort();
    int ndone; logic [31:0] v;
    load_reg(4'd2, 32'd5);
    load_reg(4'd3, 32'd3);
    load_reg(4'd4, 32'h44);
    @(negedge clk);
    start = 1'b1; opcode = 3'd0; ra = 4'd2; rb = 4'd3; rc = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy: got %b expected 0", busy); end
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL clr_hilo: got %h expected 0", {hi, lo}); end
    read_reg(4'd2, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL clr_r2: got %h expected 0", v); end
    read_reg(4'd4, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL clr_r4: got %h expected 0", v); end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL clr_no_done: got %0d expected 0", ndone); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_logic();
    test_mul();
    test_r0_illegal();
    test_back_to_back();
    test_clr_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
